// File: rtl/uart_hd_scheduler.sv
// uart_hd_scheduler: round-robin arbiter sharing one half-duplex UART among NREQ clients
// Define UART_HD_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC cycles.
module uart_hd_scheduler #(
  parameter int NREQ        = 4,
  parameter int GUARD_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              ack,
  output logic              err,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic [7:0]        u_din,
  output logic [1:0]        u_tx_mode,
  output logic              u_start,
  output logic              u_stop,
  input  logic [7:0]        u_dout,
  input  logic              u_done
);
  localparam int PW = $clog2(NREQ);
  localparam int GW = GUARD_CYC > 1 ? $clog2(GUARD_CYC) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CLOSE, S_GUARD} state_t;
  state_t state, nxt;
  logic [PW-1:0] ptr, win;
  logic [GW-1:0] gcnt;
  logic [1:0] mode;
  logic any, bad, fin, tmo, guard_last;
  assign any        = |req;
  assign mode       = req_mode[2*int'(win) +: 2];
  assign bad        = mode[0] == mode[1];
  assign fin        = u_done || tmo;
  assign guard_last = int'(gcnt) == GUARD_CYC - 1;
  assign ack        = state == S_CLOSE;
  assign u_stop     = state == S_CLOSE;
  assign u_start    = state != S_LAUNCH;
  assign busy       = state != S_IDLE;
`ifdef UART_HD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == S_WAIT && !u_done && int'(tcnt) == TIMEOUT_CYC - 1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tcnt <= '0;
    else if (state == S_LAUNCH) tcnt <= '0;
    else if (state == S_WAIT) tcnt <= tcnt + 1'b1;
`else
  assign tmo = TIMEOUT_CYC < 0;
`endif
  // Descending scan so the requester closest at-or-after ptr wins last.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NREQ]) win = PW'((int'(ptr) + i) % NREQ);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = any ? (bad ? S_CLOSE : S_LAUNCH) : S_IDLE;
      S_LAUNCH: nxt = S_WAIT;
      S_WAIT:   nxt = fin ? S_CLOSE : S_WAIT;
      S_CLOSE:  nxt = GUARD_CYC > 0 ? S_GUARD : S_IDLE;
      S_GUARD:  nxt = guard_last ? S_IDLE : S_GUARD;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gnt       <= '0;
      err       <= 1'b0;
      rd_data   <= '0;
      u_din     <= '0;
      u_tx_mode <= '0;
      ptr       <= '0;
      gcnt      <= '0;
    end else begin
      gcnt <= state == S_GUARD ? gcnt + 1'b1 : '0;
      if (state == S_IDLE && any) begin
        gnt <= NREQ'(1) << win;
        ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
        err <= bad;
        if (!bad) begin
          u_din     <= req_data[8*int'(win) +: 8];
          u_tx_mode <= mode;
        end
      end
      if (state == S_WAIT && fin) begin
        rd_data <= u_done ? u_dout : '0;
        err     <= !u_done;
      end
      if (state == S_CLOSE) begin
        gnt       <= '0;
        u_tx_mode <= '0;
        err       <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_hd_scheduler.sv
// tb_uart_hd_scheduler: random request rounds scored against a round-robin service model
module tb_uart_hd_scheduler;
  localparam int N = 4;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, gnt;
  logic [2*N-1:0] req_mode;
  logic [8*N-1:0] req_data;
  logic ack, err, busy, u_start, u_stop, u_done;
  logic [7:0] rd_data, u_din, u_dout;
  logic [1:0] u_tx_mode;
  typedef struct {
    int id;
    logic err;
    logic [7:0] rd;
    logic [1:0] mode;
    int starts;
  } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0, ptr = 0, starts = 0;
  logic [7:0] last_rd = 8'h00;
  bit uart_en = 1'b1;

  uart_hd_scheduler #(.NREQ(N), .GUARD_CYC(2), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_data(req_data),
    .gnt(gnt), .ack(ack), .err(err), .rd_data(rd_data), .busy(busy),
    .u_din(u_din), .u_tx_mode(u_tx_mode), .u_start(u_start), .u_stop(u_stop),
    .u_dout(u_dout), .u_done(u_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endfunction

  function automatic logic [1:0] rmode();
    int r = $urandom_range(0, 9);
    return r < 4 ? 2'b01 : r < 8 ? 2'b10 : r == 8 ? 2'b00 : 2'b11;
  endfunction

  // UART stand-in: answers a launched frame with the inverted tx byte, plus stray done pulses while idle
  initial begin
    u_done = 1'b0;
    u_dout = 8'h00;
    forever begin
      @(negedge clk);
      u_done = 1'b0;
      if (uart_en && rst && !u_start) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        u_dout = ~u_din;
        u_done = 1'b1;
      end else if (uart_en && rst && !busy && $urandom_range(0, 7) == 0) begin
        u_dout = 8'($urandom);
        u_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) starts = 0;
      else begin
        if (!u_start) starts++;
        if (ack) begin
          if (q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL ack_unexpected: got gnt %0h expected no ack", gnt);
          end else begin
            e = q.pop_front();
            chk("ack_gnt", 32'(gnt), 32'(1) << e.id);
            chk("ack_err", 32'(err), 32'(e.err));
            chk("ack_rd_data", 32'(rd_data), 32'(e.rd));
            chk("ack_tx_mode", 32'(u_tx_mode), 32'(e.mode));
            chk("ack_stop", 32'(u_stop), 32'd1);
            chk("start_pulses", 32'(starts), 32'(e.starts));
          end
          starts = 0;
        end
      end
    end
  end

  task automatic round(input logic [N-1:0] mask, input logic [2*N-1:0] md,
                       input logic [8*N-1:0] dt, input bit tmo);
    int first = -1, last = -1, cyc = 0;
    logic [1:0] m;
    bit bad;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      int j = (ptr + k) % N;
      if (mask[j]) begin
        m = md[2*j +: 2];
        bad = m == 2'b00 || m == 2'b11;
        e.id = j;
        e.err = bad || tmo;
        e.rd = bad ? last_rd : tmo ? 8'h00 : ~dt[8*j +: 8];
        e.mode = bad ? 2'b00 : m;
        e.starts = bad ? 0 : 1;
        q.push_back(e);
        last_rd = e.rd;
        if (first < 0) first = j;
        last = j;
      end
    end
    ptr = (last + 1) % N;
    @(negedge clk);
    req_mode = md;
    req_data = dt;
    req = mask;
    @(negedge clk);
    chk("gnt_first", 32'(gnt), 32'(1) << first);
    chk("busy_first", 32'(busy), 32'd1);
    while ((req != 0 || busy) && cyc < 3000) begin
      if (|gnt && (ack || $urandom_range(0, 3) == 0)) req &= ~gnt;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) begin
      errs++;
      $display("FAIL round_timeout: got req %0h busy %0b expected idle", req, busy);
      req = '0;
      q.delete();
    end
    chk("sb_drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] md;
    rst = 1'b0;
    req = '0;
    req_mode = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_din", 32'(u_din), 32'd0);
    chk("rst_tx_mode", 32'(u_tx_mode), 32'd0);
    chk("rst_start", 32'(u_start), 32'd1);
    chk("rst_stop", 32'(u_stop), 32'd0);
    rst = 1'b1;
    round(4'b0001, 8'b00_00_00_01, 32'h0000_00C3, 1'b0);
    round(4'b0100, 8'b00_10_00_00, 32'h003E_0000, 1'b0);
    round(4'b0010, 8'b00_00_11_00, 32'h0000_5500, 1'b0);
    round(4'b1111, 8'b10_01_10_01, 32'($urandom), 1'b0);
    round(4'b1111, 8'b01_10_01_10, 32'($urandom), 1'b0);
    // Asynchronous reset while a frame sits in WAIT with the UART silent
    uart_en = 1'b0;
    @(negedge clk);
    req_mode = 8'b00_01_00_00;
    req_data = 32'h0077_0000;
    req = 4'b0100;
    for (int c = 0; c < 20 && u_start; c++) @(negedge clk);
    chk("launch_seen", 32'(u_start), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(u_start), 32'd1);
    chk("mid_rst_stop", 32'(u_stop), 32'd0);
    chk("mid_rst_tx_mode", 32'(u_tx_mode), 32'd0);
    chk("mid_rst_din", 32'(u_din), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ptr = 0;
    last_rd = 8'h00;
    uart_en = 1'b1;
    round(4'b1111, 8'b01_01_10_10, 32'($urandom), 1'b0);
`ifdef UART_HD_TIMEOUT_EN
    uart_en = 1'b0;
    round(4'b0010, 8'b00_00_01_00, 32'h0000_A500, 1'b1);
    uart_en = 1'b1;
`endif
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) md[2*i +: 2] = rmode();
      round(N'($urandom_range(1, (1 << N) - 1)), md, 32'($urandom), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
